// File: rtl/spi_main.sv
// rtl/spi_main.sv - SPI main: shifts one {op,addr,data} frame out on mosi, then
// shifts the sub's response frame in on miso and reports data plus header mismatch.
module spi_main #(
  parameter int MSG_W      = 44,
  parameter int TURNAROUND = 1,
  parameter int CS_GAP     = 2
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  localparam int LAST_RECV = 2 * MSG_W + TURNAROUND;
  localparam int CNT_W     = $clog2(LAST_RECV + 1) + 1;
  localparam int GAP_LAST  = (CS_GAP > 0) ? CS_GAP - 1 : 0;
  localparam int GAP_W     = $clog2(GAP_LAST + 1) + 1;

  localparam logic [CNT_W-1:0] C_SEND_END = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] C_TURN_END = CNT_W'(MSG_W + TURNAROUND);
  localparam logic [CNT_W-1:0] C_RECV_END = CNT_W'(LAST_RECV);
  localparam logic [GAP_W-1:0] C_GAP_END  = GAP_W'(GAP_LAST);

  typedef enum logic [2:0] {IDLE, SEND, TURN, RECV, GAP} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [GAP_W-1:0]  r_gap;
  logic [MSG_W-1:0]  r_tx;
  logic [MSG_W-2:0]  r_rx;
  logic [11:0]       r_hdr;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_cs_n;
  logic              r_mosi;
  logic [31:0]       r_rdata;

  logic              w_legal;
  logic              w_in_frame;
  logic [MSG_W-1:0]  w_frame;
  logic [MSG_W-1:0]  w_rx_next;

  assign w_legal    = (op == 2'b00) || (op == 2'b01);
  assign w_in_frame = (r_state == SEND) || (r_state == TURN) || (r_state == RECV);
  assign w_frame    = {op, addr, (op == 2'b01) ? wdata : 32'h0};
  // The edge that samples the last miso bit also closes the frame, so use the
  // shift value including that bit.
  assign w_rx_next  = {r_rx, miso};

  assign busy     = r_busy;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign resp_err = r_err;
  assign cs_n     = r_cs_n;
  assign mosi     = r_mosi;

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_hdr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cs_n  <= 1'b1;
      r_mosi  <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_done <= 1'b0;
      if (abort && w_in_frame) begin
        r_cs_n  <= 1'b1;
        r_mosi  <= 1'b0;
        r_gap   <= '0;
        r_state <= GAP;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (w_legal) begin
                r_hdr   <= w_frame[MSG_W-1 -: 12];
                r_mosi  <= w_frame[MSG_W-1];
                r_tx    <= {w_frame[MSG_W-2:0], 1'b0};
                r_rx    <= '0;
                r_cnt   <= CNT_W'(1);
                r_cs_n  <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= SEND;
              end else begin
                r_done <= 1'b1;
                r_err  <= 1'b1;
              end
            end
          end
          SEND: begin
            r_mosi <= r_tx[MSG_W-1];
            r_tx   <= {r_tx[MSG_W-2:0], 1'b0};
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == C_SEND_END) begin
              r_state <= TURN;
            end
          end
          TURN: begin
            r_mosi <= 1'b0;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == C_TURN_END) begin
              r_state <= RECV;
            end
          end
          RECV: begin
            r_rx  <= w_rx_next[MSG_W-2:0];
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == C_RECV_END) begin
              r_cs_n  <= 1'b1;
              r_rdata <= w_rx_next[31:0];
              r_err   <= (w_rx_next[MSG_W-1 -: 12] != r_hdr);
              r_done  <= 1'b1;
              r_gap   <= '0;
              r_state <= GAP;
            end
          end
          GAP: begin
            if (r_gap == C_GAP_END) begin
              r_busy  <= 1'b0;
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_gap <= r_gap + GAP_W'(1);
            end
          end
          default: begin
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_main.sv
// tb/tb_spi_main.sv - randomized bench for spi_main with a sub + memory model
// and a frame-level reference memory.
module tb_spi_main;

  localparam int MSG_W = 44;
  localparam int TURN  = 1;
  localparam int GAP   = 2;
  localparam int DONE_AT = 2 * MSG_W + TURN;
  localparam int IDLE_AT = DONE_AT + GAP;
  localparam int MEM_AT  = MSG_W + TURN;

  logic        sclk = 1'b0;
  logic        rst, start, abort, miso;
  logic [1:0]  op;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        busy, done, resp_err, cs_n, mosi;
  logic [31:0] rdata;

  always #5 sclk = ~sclk;

  spi_main #(.MSG_W(MSG_W), .TURNAROUND(TURN), .CS_GAP(GAP)) dut (
    .sclk(sclk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .abort(abort), .busy(busy), .done(done), .rdata(rdata), .resp_err(resp_err),
    .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sub device: collects MSG_W bits, accesses memory TURN cycles later,
  // then returns a MSG_W-bit response MSB first.
  logic [31:0] sub_mem [int];
  logic [43:0] sub_rx, sub_resp, sub_frame;
  logic        sub_w_en, sub_r_en;
  bit          sub_corrupt = 0;
  int          sub_cnt;

  always @(posedge sclk) begin
    sub_w_en <= 1'b0;
    sub_r_en <= 1'b0;
    if (rst || cs_n !== 1'b0) begin
      sub_cnt <= 0;
      miso    <= 1'b0;
    end else begin
      sub_cnt <= sub_cnt + 1;
      if (sub_cnt < MSG_W) sub_rx = {sub_rx[42:0], mosi};
      if (sub_cnt == MEM_AT - 1) begin
        sub_frame = sub_rx;
        if (sub_rx[43:42] == 2'b01) begin
          sub_mem[int'(sub_rx[41:32])] = sub_rx[31:0];
          sub_resp = sub_rx;
          sub_w_en <= 1'b1;
        end else begin
          sub_resp = {sub_rx[43:32],
                      sub_mem.exists(int'(sub_rx[41:32])) ? sub_mem[int'(sub_rx[41:32])] : 32'h0};
          sub_r_en <= 1'b1;
        end
        if (sub_corrupt) sub_resp[41:32] = 10'h000;
      end
      if (sub_cnt >= MEM_AT - 1 && sub_cnt < DONE_AT - 1)
        miso <= sub_resp[DONE_AT - 2 - sub_cnt];
      else
        miso <= 1'b0;
    end
  end

  // Event counters and shortest cs_n-high run between frames.
  int done_cnt = 0, wen_cnt = 0, ren_cnt = 0, cs_low_cnt = 0;
  int hi_run = 0, min_gap = 1000;
  bit seen_low = 0;
  always @(negedge sclk) begin
    if (done === 1'b1) done_cnt++;
    if (sub_w_en === 1'b1) wen_cnt++;
    if (sub_r_en === 1'b1) ren_cnt++;
    if (cs_n === 1'b0) begin
      cs_low_cnt++;
      if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run   = 0;
      seen_low = 1;
    end else begin
      hi_run++;
    end
  end

  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_read(input logic [9:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  task automatic run_frame(input logic [1:0] f_op, input logic [9:0] f_addr, input logic [31:0] f_data,
                           input bit spurious, input bit ab_idle_gap, input bit now, input string tag);
    logic [43:0] exp_frame;
    logic [31:0] exp_data;
    int n, wen_at, ren_at;
    exp_frame = {f_op, f_addr, (f_op == 2'b01) ? f_data : 32'h0};
    exp_data  = (f_op == 2'b01) ? f_data : ref_read(f_addr);
    if (!now) @(negedge sclk);
    start = 1'b1; op = f_op; addr = f_addr; wdata = f_data; abort = ab_idle_gap;
    @(negedge sclk);
    start = 1'b0; abort = 1'b0;
    op = 2'($urandom_range(3)); addr = 10'($urandom); wdata = $urandom;
    check_val($sformatf("%s.cs_low", tag), cs_n, 1'b0);
    n = 0; wen_at = -1; ren_at = -1;
    while (done !== 1'b1 && n < 200) begin
      @(negedge sclk);
      n++;
      start = spurious && (n == 30);
      if (sub_w_en === 1'b1) wen_at = n;
      if (sub_r_en === 1'b1) ren_at = n;
    end
    start = 1'b0;
    check_val($sformatf("%s.done_cyc", tag), n, DONE_AT);
    check_val($sformatf("%s.frame", tag), sub_frame, exp_frame);
    check_val($sformatf("%s.rdata", tag), rdata, exp_data);
    check_val($sformatf("%s.resp_err", tag), resp_err, sub_corrupt);
    check_val($sformatf("%s.mem_en", tag), {wen_at, ren_at},
              (f_op == 2'b01) ? {MEM_AT, -1} : {-1, MEM_AT});
    if (f_op == 2'b01) ref_mem[int'(f_addr)] = f_data;
    abort = ab_idle_gap;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge sclk);
      n++;
      abort = 1'b0;
    end
    abort = 1'b0;
    check_val($sformatf("%s.busy_drop", tag), n, IDLE_AT);
    @(negedge sclk);
    check_val($sformatf("%s.no_queue", tag), {cs_n, busy}, 2'b10);
  endtask

  logic [9:0]  pool [8];
  logic [31:0] rd0;
  int d0, w0, r0, c0, n;

  initial begin
    pool = '{10'h001, 10'h0F0, 10'h111, 10'h1A5, 10'h222, 10'h2AA, 10'h333, 10'h3FF};
    rst = 1'b1; start = 1'b1; abort = 1'b1; op = 2'b01; addr = 10'h155; wdata = 32'h12345678;

    repeat (2) @(negedge sclk);
    check_val("rst.cs_n", cs_n, 1'b1);
    check_val("rst.mosi", mosi, 1'b0);
    check_val("rst.busy", busy, 1'b0);
    check_val("rst.done", done, 1'b0);
    check_val("rst.resp_err", resp_err, 1'b0);
    check_val("rst.rdata", rdata, 32'h0);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge sclk);
    check_val("rst.no_accept", {cs_n, busy}, 2'b10);

    run_frame(2'b01, 10'h333, 32'hCCCCCCCC, 0, 0, 0, "wr333");
    run_frame(2'b01, 10'h1A5, 32'hDEADBEEF, 0, 0, 0, "wr1a5");
    run_frame(2'b00, 10'h1A5, 32'h0BADF00D, 0, 0, 0, "rd1a5");

    for (int i = 0; i < 16; i++) begin
      run_frame(2'($urandom_range(1)), pool[$urandom_range(7)], $urandom,
                1'($urandom_range(1)), 1'($urandom_range(1)), 0, $sformatf("rnd%0d", i));
    end
    check_val("cs_gap_min", min_gap >= GAP && min_gap < 1000, 1'b1);

    // Abort a write after 20 mosi bits.
    d0 = done_cnt; w0 = wen_cnt; r0 = ren_cnt; rd0 = rdata;
    @(negedge sclk);
    start = 1'b1; op = 2'b01; addr = 10'h111; wdata = 32'hA5A5_5A5A;
    @(negedge sclk);
    start = 1'b0;
    repeat (19) @(negedge sclk);
    abort = 1'b1;
    @(negedge sclk);
    abort = 1'b0;
    check_val("abort.cs_n", cs_n, 1'b1);
    check_val("abort.mosi", mosi, 1'b0);
    n = 20;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge sclk);
      n++;
    end
    check_val("abort.busy_drop", n, 20 + GAP);
    repeat (100) @(negedge sclk);
    check_val("abort.no_done", done_cnt, d0);
    check_val("abort.no_mem", {wen_cnt, ren_cnt}, {w0, r0});
    check_val("abort.rdata", rdata, rd0);
    run_frame(2'b00, 10'h111, 32'h0, 0, 0, 0, "rd111");

    // Illegal op codes never open a frame.
    for (int k = 2; k < 4; k++) begin
      c0 = cs_low_cnt; d0 = done_cnt; rd0 = rdata;
      @(negedge sclk);
      start = 1'b1; op = 2'(k); addr = 10'($urandom); wdata = $urandom;
      @(negedge sclk);
      start = 1'b0;
      check_val($sformatf("ill%0d.done", k), {done, resp_err}, 2'b11);
      check_val($sformatf("ill%0d.busy", k), busy, 1'b0);
      check_val($sformatf("ill%0d.rdata", k), rdata, rd0);
      @(negedge sclk);
      check_val($sformatf("ill%0d.one_pulse", k), {done, busy}, 2'b00);
      repeat (5) @(negedge sclk);
      check_val($sformatf("ill%0d.cs_quiet", k), cs_low_cnt, c0);
      check_val($sformatf("ill%0d.done_cnt", k), done_cnt, d0 + 1);
    end

    // Reset during RECV after 14 miso bits, then an immediate write.
    run_frame(2'b00, 10'h000, 32'h0, 0, 0, 0, "rd000");
    d0 = done_cnt;
    @(negedge sclk);
    start = 1'b1; op = 2'b00; addr = 10'h1A5; wdata = 32'h0;
    @(negedge sclk);
    start = 1'b0;
    repeat (MEM_AT + 14) @(negedge sclk);
    rst = 1'b1;
    @(negedge sclk);
    check_val("rstmid.cs_n", cs_n, 1'b1);
    check_val("rstmid.busy", busy, 1'b0);
    check_val("rstmid.rdata", rdata, 32'h0);
    rst = 1'b0;
    run_frame(2'b01, 10'h555, 32'hEEEEEEEE, 0, 0, 1, "wr555");
    check_val("rstmid.done_cnt", done_cnt, d0 + 1);

    // Sub echoes a wrong address.
    run_frame(2'b01, 10'h222, 32'h2222_BEEF, 0, 0, 0, "wr222");
    sub_corrupt = 1;
    run_frame(2'b00, 10'h222, 32'h0, 0, 0, 0, "rd222bad");
    sub_corrupt = 0;
    run_frame(2'b00, 10'h555, 32'h0, 0, 0, 0, "rd555");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
